multi_cycle_control: RTL and testbench

Multi-cycle MIPS control unit: a Moore/Mealy finite-state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps over a shared ALU and a single memory port. It sits between the instruction register opcode field and the multi-cycle datapath, driving the datapath's mux selects, write enables and 4-bit ALU operation code. It supersedes the single-cycle opcode decoder by adding:
- a variable-latency memory handshake with timeout;
- a sticky fault state;
- full immediate-class coverage.

---
 rtl/multi_cycle_control.sv | 257 +++++++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle MIPS control FSM.
// Each instruction runs through fetch, decode, execute, memory and write-back
// steps over a shared ALU and a single memory port. Memory accesses wait on
// MemReady and have an optional timeout. Timeouts and illegal opcodes lead to
// a sticky FAULT state.
// Optional feature macro: ILLEGAL_OP_TRAP_EN. When it is defined, an undefined
// opcode traps to FAULT. When it is undefined, an undefined opcode is a NOP.
module multi_cycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       SignExtend,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic [3:0] State,
  output logic       Fault,
  output logic [1:0] FaultCode
);

  // Counter width. A timeout of 0 disables the counter, but one bit is kept
  // so that the declaration stays legal.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12,
    S_FAULT  = 4'd13
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_ADDU  = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_SLTU  = 4'b1011;
  localparam logic [3:0] ALU_LUI   = 4'b1110;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fcode_q, fcode_d;
  // LW/SW choice is captured in DECODE. Opcode is not stable in MEMADR.
  logic          store_q, store_d;

  logic is_imm;
  assign is_imm = (Opcode[5:3] == 3'b001);

  // Selects the ALU operation for the immediate class in IEXEC.
  function automatic logic [3:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ADDI:  imm_aluop = ALU_ADD;
      OP_ADDIU: imm_aluop = ALU_ADDU;
      OP_SLTI:  imm_aluop = ALU_SLT;
      OP_SLTIU: imm_aluop = ALU_SLTU;
      OP_ANDI:  imm_aluop = ALU_AND;
      OP_ORI:   imm_aluop = ALU_OR;
      OP_XORI:  imm_aluop = ALU_XOR;
      default:  imm_aluop = ALU_LUI;
    endcase
  endfunction

  // State register, wait counter, fault code and latched store flag.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      fcode_q <= 2'b00;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcode_q <= fcode_d;
      store_q <= store_d;
    end
  end

  // Next-state logic with the memory wait and timeout handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcode_d = fcode_q;
    store_d = store_q;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (MemReady) begin
          // A completing access wins over a timeout in the same cycle.
          if (state_q == S_FETCH)      state_d = S_DECODE;
          else if (state_q == S_MEMRD) state_d = S_MEMWB;
          else                         state_d = S_FETCH;
        end else if (MEM_TIMEOUT != 0) begin
          if (cnt_q == TMO) begin
            state_d = S_FAULT;
            fcode_d = FC_TIMEOUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DECODE: begin
        store_d = (Opcode == OP_SW);
        if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEMADR;
        else if (Opcode == OP_R)                state_d = S_REXEC;
        else if (Opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (Opcode == OP_J)                state_d = S_JUMP;
        else if (is_imm)                        state_d = S_IEXEC;
        else begin
`ifdef ILLEGAL_OP_TRAP_EN
          state_d = S_FAULT;
          fcode_d = FC_ILLEGAL;
`else
          // The PC has already advanced in FETCH, so the instruction acts as a NOP.
          state_d = S_FETCH;
`endif
        end
      end
      S_MEMADR: state_d = store_q ? S_MEMWR : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_INIT;
    endcase
    // Every state starts its wait count from zero.
    if (state_d != state_q) cnt_d = '0;
  end

  // Datapath controls decoded from the current state. FETCH also uses MemReady.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    SignExtend  = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = ALU_AND;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ALUOp      = ALU_ADD;
        SignExtend = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = ALU_ADD;
        SignExtend = 1'b1;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = imm_aluop(Opcode);
        SignExtend = (Opcode[5:2] == 4'b0010);
      end
      S_IWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign State     = state_q;
  assign Fault     = (state_q == S_FAULT);
  assign FaultCode = fcode_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: scoreboard bench for the multi-cycle control FSM.
// Each instruction is expanded into a per-cycle path of states, and the
// expected controls are computed from the state/control table.
module tb_multi_cycle_control;
  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       MemReady = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg;
  logic RegWrite, RegDst, ALUSrcA, SignExtend, Fault;
  logic [1:0] ALUSrcB, PCSource, FaultCode;
  logic [3:0] ALUOp, State;

  multi_cycle_control #(.MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .SignExtend(SignExtend), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .State(State), .Fault(Fault),
    .FaultCode(FaultCode)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       flt;
    logic [1:0] fc;
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, sext;
    logic [1:0] srcb, pcsrc;
    logic [3:0] aop;
  } ctrl_t;

  typedef struct {
    logic       mr;
    logic [5:0] op;
    ctrl_t      exp;
  } step_t;

  ctrl_t dut_vec;
  assign dut_vec = {State, Fault, FaultCode, PCWrite, PCWriteCond, IorD, MemRead,
                    MemWrite, IRWrite, MemToReg, RegWrite, RegDst, ALUSrcA,
                    SignExtend, ALUSrcB, PCSource, ALUOp};

  step_t plan[$];
  ctrl_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  logic [5:0] legal_ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000010, 6'b001000, 6'b001001, 6'b001010,
                                 6'b001011, 6'b001100, 6'b001101, 6'b001110};

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Expected controls for one cycle in state st (0..13), taken from the state table.
  function automatic ctrl_t expv(int st, logic mr, logic [5:0] op, logic [1:0] fc);
    ctrl_t c = '0;
    c.st = 4'(st);
    case (st)
      1:  begin c.mrd = 1; c.srcb = 2'b01; c.aop = 4'b0010; c.irw = mr; c.pcw = mr; end
      2:  begin c.srcb = 2'b11; c.aop = 4'b0010; c.sext = 1; end
      3:  begin c.srca = 1; c.srcb = 2'b10; c.aop = 4'b0010; c.sext = 1; end
      4:  begin c.mrd = 1; c.iord = 1; end
      5:  begin c.rw = 1; c.m2r = 1; end
      6:  begin c.mwr = 1; c.iord = 1; end
      7:  begin c.srca = 1; c.aop = 4'b1111; end
      8:  begin c.rw = 1; c.rdst = 1; end
      9:  begin c.srca = 1; c.aop = 4'b0110; c.pcwc = 1; c.pcsrc = 2'b01; end
      10: begin c.pcw = 1; c.pcsrc = 2'b10; end
      11: begin
        c.srca = 1; c.srcb = 2'b10;
        case (op)
          6'b001000: begin c.aop = 4'b0010; c.sext = 1; end
          6'b001001: begin c.aop = 4'b1000; c.sext = 1; end
          6'b001010: begin c.aop = 4'b0111; c.sext = 1; end
          6'b001011: begin c.aop = 4'b1011; c.sext = 1; end
          6'b001100: c.aop = 4'b0000;
          6'b001101: c.aop = 4'b0001;
          6'b001110: c.aop = 4'b1010;
          default:   c.aop = 4'b1110;
        endcase
      end
      12: c.rw = 1;
      13: begin c.flt = 1; c.fc = fc; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic add(int st, logic mr, logic [5:0] op, logic [1:0] fc = 2'b00);
    step_t s;
    s.mr = mr; s.op = op; s.exp = expv(st, mr, op, fc);
    plan.push_back(s);
  endtask

  task automatic check(string name, ctrl_t got, ctrl_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Expands one instruction into a cycle-by-cycle path.
  // wf is the number of fetch wait cycles and wm the number of data-access wait cycles.
  task automatic plan_instr(logic [5:0] op, int wf, int wm, output bit faulted);
    faulted = 0;
    repeat (wf) add(1, 0, rop());
    add(1, 1, rop());
    add(2, rbit(), op);
    if (op == LW || op == SW) begin
      add(3, rbit(), rop());
      repeat (wm) add(op == LW ? 4 : 6, 0, rop());
      add(op == LW ? 4 : 6, 1, rop());
      if (op == LW) add(5, rbit(), rop());
    end else if (op == RT) begin
      add(7, rbit(), rop()); add(8, rbit(), rop());
    end else if (op == BEQ) add(9, rbit(), rop());
    else if (op == JMP) add(10, rbit(), rop());
    else if (op[5:3] == 3'b001) begin
      add(11, rbit(), op); add(12, rbit(), rop());
    end else begin
`ifdef ILLEGAL_OP_TRAP_EN
      add(13, rbit(), rop(), 2'b10); add(13, rbit(), rop(), 2'b10);
      faulted = 1;
`endif
    end
  endtask

  task automatic run_plan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge CLK); #1;
      MemReady = s.mr; Opcode = s.op;
      sb.push_back(s.exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK); #1;
    Reset = 1; MemReady = 0; Opcode = rop();
    #1 check("rst_async", dut_vec, ctrl_t'(0));
    repeat (3) begin
      @(posedge CLK); #1;
      check("rst_hold", dut_vec, ctrl_t'(0));
    end
    Reset = 0;
    sb.push_back(expv(0, 0, 0, 0));
  endtask

  // Monitor: on every falling edge, compare the DUT against the next expected cycle.
  always @(negedge CLK) begin
    if (!Reset && sb.size() > 0) check("ctrl", dut_vec, sb.pop_front());
  end

  initial begin
    bit f;
    logic [5:0] op;
    do_reset();
    plan_instr(ADDI, 0, 0, f); run_plan();
    plan_instr(LW, 0, 3, f); run_plan();
    plan_instr(SW, 0, TO, f); plan_instr(LW, TO, TO, f); run_plan();
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 7) == 0) ? rop() : legal_ops[$urandom_range(0, 11)];
      plan_instr(op, $urandom_range(0, TO), $urandom_range(0, TO), f);
      run_plan();
      if (f) do_reset();
    end
    // Fetch timeout.
    repeat (TO + 1) add(1, 0, rop());
    repeat (3) add(13, rbit(), rop(), 2'b01);
    run_plan();
    do_reset();
    // Data-read timeout.
    add(1, 1, rop()); add(2, 0, LW); add(3, 0, rop());
    repeat (TO + 1) add(4, 0, rop());
    repeat (2) add(13, rbit(), rop(), 2'b01);
    run_plan();
    do_reset();
    // Undefined opcode: traps or falls back to fetch.
    plan_instr(6'b111111, 0, 0, f);
    if (!f) plan_instr(JMP, 0, 0, f);
    run_plan();
    if (f) do_reset();
    // Reset during a pending store.
    add(1, 1, rop()); add(2, 0, SW); add(3, 0, rop());
    add(6, 0, rop()); add(6, 0, rop());
    run_plan();
    @(negedge CLK); #1;
    Reset = 1;
    #1 check("rst_in_memwr", dut_vec, ctrl_t'(0));
    do_reset();
    plan_instr(RT, 1, 0, f); run_plan();
    @(negedge CLK); #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
